// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch port
// and the data port of the core. One requester is granted at a time. The
// transaction is registered onto the memory bus. Completion comes back as a
// one-cycle ack pulse with read data.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a memory access that
// gets no m_ack within TIMEOUT_CYCLES busy cycles. An aborted access returns
// 32'hDEADBEEF to the owner and raises the sticky err flag. Without the macro,
// BUSY waits for m_ack indefinitely and err is tied low.

package mem_arbiter_pkg;

  // Access size/sign encoding shared with the core's load/store unit.
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_t;

endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,

  // instruction-fetch requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,

  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  mem_op_t           d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,

  // downstream memory
  output logic              m_req,
  output logic              m_we,
  output mem_op_t           m_op,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,

  // status
  output logic              busy,
  output logic              err
);

  // The streak counter must hold STARVE_LIMIT itself and is never narrower than 3 bits.
  localparam int STREAK_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [STREAK_W-1:0] STARVE_MAX = STREAK_W'(STARVE_LIMIT);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // owner encoding: 0 = fetch port, 1 = data port
  state_t              state_reg,   state_next;
  logic                owner_reg,   owner_next;
  logic                m_req_reg,   m_req_next;
  logic                m_we_reg,    m_we_next;
  mem_op_t             m_op_reg,    m_op_next;
  logic [ADDR_W-1:0]   m_addr_reg,  m_addr_next;
  logic [DATA_W-1:0]   m_wdata_reg, m_wdata_next;
  logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
  logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
  logic                i_ack_reg,   i_ack_next;
  logic                d_ack_reg,   d_ack_next;
  logic [STREAK_W-1:0] streak_reg,  streak_next;

  // Completion request for the current BUSY cycle and the word handed back.
  logic                resp_go;
  logic [DATA_W-1:0]   resp_word;

  // The data port wins unless the fetch port is waiting and has been
  // passed over STARVE_LIMIT times in a row.
  logic                grant_data;
  assign grant_data = d_req && (!i_req || (streak_reg < STARVE_MAX));

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TO_W-1:0]   TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_ONE       = TO_W'(1);
  localparam logic [DATA_W-1:0] TIMEOUT_WORD = DATA_W'(32'hDEADBEEF);

  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            err_reg,    err_next;
`else
  // The timeout depth only matters when the timeout is compiled in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and next-output logic; every register holds unless changed here.
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    m_req_next   = m_req_reg;
    m_we_next    = m_we_reg;
    m_op_next    = m_op_reg;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;
    i_ack_next   = 1'b0;
    d_ack_next   = 1'b0;
    streak_next  = streak_reg;
    resp_go      = 1'b0;
    resp_word    = m_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    to_cnt_next  = to_cnt_reg;
    err_next     = err_reg;
`endif

    case (state_reg)
      IDLE: begin
        // With no fetch waiting, the fetch port cannot be starving.
        if (!i_req) begin
          streak_next = '0;
        end
        if (i_req || d_req) begin
          state_next = BUSY;
          m_req_next = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          to_cnt_next = '0;
`endif
          if (grant_data) begin
            owner_next   = 1'b1;
            m_we_next    = d_we;
            m_op_next    = d_op;
            m_addr_next  = d_addr;
            m_wdata_next = d_wdata;
            // Count only grants that make a waiting fetch wait longer.
            if (i_req && (streak_reg < STARVE_MAX)) begin
              streak_next = streak_reg + STREAK_ONE;
            end
          end else begin
            owner_next   = 1'b0;
            m_we_next    = 1'b0;
            m_op_next    = MEM_W;
            m_addr_next  = i_addr;
            m_wdata_next = '0;
            streak_next  = '0;
          end
        end
      end

      BUSY: begin
        if (m_ack) begin
          resp_go = 1'b1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // A real m_ack on the expiry cycle takes priority over the abort.
        else if (to_cnt_reg == TO_LAST) begin
          resp_go   = 1'b1;
          resp_word = TIMEOUT_WORD;
          err_next  = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + TO_ONE;
        end
`endif
        if (resp_go) begin
          state_next = RESP;
          m_req_next = 1'b0;
          if (owner_reg) begin
            d_ack_next   = 1'b1;
            d_rdata_next = resp_word;
          end else begin
            i_ack_next   = 1'b1;
            i_rdata_next = resp_word;
          end
        end
      end

      RESP: begin
        // The owner's ack pulse is on the outputs this cycle. The requester
        // updates its req before the next IDLE sample, so it is never re-granted.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        m_req_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      owner_reg   <= 1'b0;
      m_req_reg   <= 1'b0;
      m_we_reg    <= 1'b0;
      m_op_reg    <= MEM_B;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
      i_ack_reg   <= 1'b0;
      d_ack_reg   <= 1'b0;
      streak_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      m_req_reg   <= m_req_next;
      m_we_reg    <= m_we_next;
      m_op_reg    <= m_op_next;
      m_addr_reg  <= m_addr_next;
      m_wdata_reg <= m_wdata_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
      i_ack_reg   <= i_ack_next;
      d_ack_reg   <= d_ack_next;
      streak_reg  <= streak_next;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Busy-cycle counter and sticky error flag for aborted accesses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      to_cnt_reg <= to_cnt_next;
      err_reg    <= err_next;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign m_req   = m_req_reg;
  assign m_we    = m_we_reg;
  assign m_op    = m_op_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;
  assign i_rdata = i_rdata_reg;
  assign d_rdata = d_rdata_reg;
  assign i_ack   = i_ack_reg;
  assign d_ack   = d_ack_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Each requester pushes the
// expected completion into its own queue when it issues a request. The queue is
// popped and checked when the matching ack pulse appears. A small memory
// responder answers m_req after a programmable number of cycles.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 8;
`else
  localparam int TIMEOUT_CYCLES = 255;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic              i_req, d_req, d_we, m_ack;
  logic [ADDR_W-1:0] i_addr, d_addr, m_addr;
  logic [DATA_W-1:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
  logic              i_ack, d_ack, m_req, m_we, busy, err;
  mem_op_t           d_op, m_op;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t sb_i[$];
  exp_t sb_d[$];

  int tests_run    = 0;
  int tests_failed = 0;

  // memory responder controls
  bit                mem_auto  = 1'b0;
  int                mem_lat   = 1;   // 0 = never answer
  logic              man_ack   = 1'b0;
  logic [DATA_W-1:0] man_rdata = '0;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_op(d_op), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_op(m_op), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0], ~a[15:0]} ^ 32'h12345678;
  endfunction

  // Memory model: m_ack on the mem_lat-th consecutive cycle of m_req.
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    m_ack    = 1'b0;
    m_rdata  = '0;
    forever begin
      @(posedge clk); #2;
      if (mem_auto) begin
        if (m_req) busy_cnt++; else busy_cnt = 0;
        if (m_req && mem_lat != 0 && busy_cnt == mem_lat) begin
          m_ack   = 1'b1;
          m_rdata = mem_word(m_addr);
        end else begin
          m_ack   = 1'b0;
          m_rdata = '0;
        end
      end else begin
        busy_cnt = 0;
        m_ack    = man_ack;
        m_rdata  = man_rdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_i(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] r);
    exp_t e;
    e.addr = a; e.rdata = r;
    sb_i.push_back(e);
  endtask

  task automatic push_d(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] r);
    exp_t e;
    e.addr = a; e.rdata = r;
    sb_d.push_back(e);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_op = MEM_W; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({m_req, busy, i_ack, d_ack, err} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_ctrl got %b want 00000", {m_req, busy, i_ack, d_ack, err});
    end
    tests_run++;
    if ({m_we, m_op, m_addr, m_wdata} !== 68'h0) begin
      tests_failed++;
      $display("FAIL reset_mfields got we=%b op=%0d addr=%h wdata=%h want all 0", m_we, m_op, m_addr, m_wdata);
    end
    tests_run++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata got i=%h d=%h want 0", i_rdata, d_rdata);
    end
    tick();
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({m_req, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_release_idle got m_req=%b busy=%b want 0 0", m_req, busy);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single_fetch();
    exp_t e;
    mem_auto = 1'b1; mem_lat = 1;
    tick();
    i_req = 1'b1; i_addr = 32'h100;
    push_i(32'h100, 32'h00500093);
    @(negedge clk);  // cycle 0
    tests_run++;
    if (m_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_c0_mreq got %b want 0", m_req);
    end
    @(negedge clk);  // cycle 1
    tests_run++;
    if ({m_req, busy, m_we, m_op, m_addr, m_wdata} !== {1'b1, 1'b1, 1'b0, MEM_W, 32'h100, 32'h0}) begin
      tests_failed++;
      $display("FAIL fetch_c1_bus got m_req=%b busy=%b we=%b op=%0d addr=%h wdata=%h want 1 1 0 2 100 0",
               m_req, busy, m_we, m_op, m_addr, m_wdata);
    end
    @(negedge clk);  // cycle 2
    tests_run++;
    if ({i_ack, d_ack} !== 2'b10) begin
      tests_failed++;
      $display("FAIL fetch_c2_ack got i_ack=%b d_ack=%b want 1 0", i_ack, d_ack);
    end
    if (i_ack === 1'b1 && sb_i.size() > 0) begin
      e = sb_i.pop_front();
      tests_run++;
      if (i_rdata !== e.rdata) begin
        tests_failed++;
        $display("FAIL fetch_rdata got %h want %h", i_rdata, e.rdata);
      end
    end
    tick();
    i_req = 1'b0;
    @(negedge clk);  // cycle 3
    tests_run++;
    if ({busy, i_ack, m_req} !== 3'b000) begin
      tests_failed++;
      $display("FAIL fetch_c3_idle got busy=%b i_ack=%b m_req=%b want 0 0 0", busy, i_ack, m_req);
    end
    sb_i.delete();
    $display("[TB] single fetch addr=100 rdata=%h", i_rdata);
  endtask

  task automatic test_store();
    exp_t e;
    int   mreq_cycles = 0, unstable = 0, dack_cnt = 0, iack_cnt = 0;
    bit   done = 1'b0;
    mem_auto = 1'b1; mem_lat = 4;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_op = MEM_W; d_addr = 32'h2000; d_wdata = 32'hCAFEF00D;
    push_d(32'h2000, mem_word(32'h2000));
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (m_req) begin
        mreq_cycles++;
        if ({m_we, m_op, m_addr, m_wdata} !== {1'b1, MEM_W, 32'h2000, 32'hCAFEF00D}) unstable++;
      end
      if (i_ack) iack_cnt++;
      if (d_ack) begin
        dack_cnt++;
        tests_run++;
        if (sb_d.size() == 0) begin
          tests_failed++;
          $display("FAIL store_sb got unexpected d_ack want none");
        end else begin
          e = sb_d.pop_front();
          if (d_rdata !== e.rdata) begin
            tests_failed++;
            $display("FAIL store_rdata got %h want %h", d_rdata, e.rdata);
          end
        end
        tick();
        d_req = 1'b0; d_we = 1'b0;
        done = 1'b1;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (d_ack) dack_cnt++;
      if (i_ack) iack_cnt++;
    end
    tests_run++;
    if (mreq_cycles != 4) begin
      tests_failed++;
      $display("FAIL store_busy_len got %0d want 4", mreq_cycles);
    end
    tests_run++;
    if (unstable != 0) begin
      tests_failed++;
      $display("FAIL store_fields_stable got %0d bad cycles want 0", unstable);
    end
    tests_run++;
    if (dack_cnt != 1 || iack_cnt != 0) begin
      tests_failed++;
      $display("FAIL store_acks got d_ack=%0d i_ack=%0d want 1 0", dack_cnt, iack_cnt);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_end_idle got busy=%b want 0", busy);
    end
    $display("[TB] store addr=2000 wdata=cafef00d busy_cycles=%0d", mreq_cycles);
  endtask

  task automatic test_contention();
    bit   want_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_t e;
    int   g = 0, acks = 0, last_c = 0;
    bit   prev_mreq = 1'b0, is_d, chg_i, chg_d, done = 1'b0;
    mem_auto = 1'b1; mem_lat = 1;
    tick();
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_op = MEM_H; d_addr = 32'h8000; d_wdata = '0;
    push_i(32'h1000, mem_word(32'h1000));
    push_d(32'h8000, mem_word(32'h8000));
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      chg_i = 1'b0; chg_d = 1'b0;
      if (m_req && !prev_mreq) begin
        is_d = m_addr[15];
        if (g < 10) begin
          tests_run++;
          if (is_d !== want_d[g]) begin
            tests_failed++;
            $display("FAIL grant_order idx=%0d got %s want %s", g, is_d ? "D" : "I", want_d[g] ? "D" : "I");
          end
        end
        tests_run++;
        if (m_op !== (is_d ? MEM_H : MEM_W)) begin
          tests_failed++;
          $display("FAIL grant_op idx=%0d got %0d want %0d", g, m_op, is_d ? MEM_H : MEM_W);
        end
        if (g > 0) begin
          tests_run++;
          if (c - last_c != 3) begin
            tests_failed++;
            $display("FAIL grant_spacing idx=%0d got %0d want 3", g, c - last_c);
          end
        end
        $display("[TB] grant %0d -> %s addr=%h", g, is_d ? "D" : "I", m_addr);
        last_c = c;
        g++;
      end
      prev_mreq = m_req;
      if (i_ack) begin
        tests_run++;
        if (sb_i.size() == 0) begin
          tests_failed++;
          $display("FAIL cont_i_sb got unexpected i_ack want none");
        end else begin
          e = sb_i.pop_front();
          if (i_rdata !== e.rdata) begin
            tests_failed++;
            $display("FAIL cont_i_rdata addr=%h got %h want %h", e.addr, i_rdata, e.rdata);
          end
        end
        chg_i = 1'b1; acks++;
      end
      if (d_ack) begin
        tests_run++;
        if (sb_d.size() == 0) begin
          tests_failed++;
          $display("FAIL cont_d_sb got unexpected d_ack want none");
        end else begin
          e = sb_d.pop_front();
          if (d_rdata !== e.rdata) begin
            tests_failed++;
            $display("FAIL cont_d_rdata addr=%h got %h want %h", e.addr, d_rdata, e.rdata);
          end
        end
        chg_d = 1'b1; acks++;
      end
      if (chg_i || chg_d) begin
        tick();
        if (acks >= 10) begin
          i_req = 1'b0; d_req = 1'b0;
          done = 1'b1;
        end else begin
          if (chg_i) begin i_addr = i_addr + 32'h4; push_i(i_addr, mem_word(i_addr)); end
          if (chg_d) begin d_addr = d_addr + 32'h4; push_d(d_addr, mem_word(d_addr)); end
        end
      end
    end
    tests_run++;
    if (g != 10 || acks != 10) begin
      tests_failed++;
      $display("FAIL cont_count got grants=%0d acks=%0d want 10 10", g, acks);
    end
    sb_i.delete(); sb_d.delete();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, m_req} !== 2'b00) begin
      tests_failed++;
      $display("FAIL cont_end_idle got busy=%b m_req=%b want 0 0", busy, m_req);
    end
  endtask

  task automatic test_spurious_ack();
    exp_t e;
    int   nbad = 0;
    logic [DATA_W-1:0] d_before;
    d_before  = d_rdata;
    mem_auto  = 1'b0; man_ack = 1'b1; man_rdata = 32'h0BADF00D;
    tick();
    repeat (4) begin
      @(negedge clk);
      if ({busy, m_req, i_ack, d_ack} !== 4'b0000) nbad++;
    end
    tests_run++;
    if (nbad != 0) begin
      tests_failed++;
      $display("FAIL spur_idle got %0d active cycles want 0", nbad);
    end
    tick();                                   // cycle 0
    man_ack = 1'b0; i_req = 1'b1; i_addr = 32'h440;
    push_i(32'h440, 32'h13579BDF);
    tick();                                   // cycle 1
    man_ack = 1'b1; man_rdata = 32'h13579BDF;
    @(negedge clk);
    tests_run++;
    if (m_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL spur_mreq got %b want 1", m_req);
    end
    tick();                                   // cycle 2: RESP with m_ack still high
    man_rdata = 32'hFFFF0000;
    @(negedge clk);
    tests_run++;
    if ({i_ack, d_ack} !== 2'b10 || sb_i.size() == 0) begin
      tests_failed++;
      $display("FAIL spur_ack got i_ack=%b d_ack=%b want 1 0", i_ack, d_ack);
    end else begin
      e = sb_i.pop_front();
      tests_run++;
      if (i_rdata !== e.rdata) begin
        tests_failed++;
        $display("FAIL spur_rdata got %h want %h", i_rdata, e.rdata);
      end
    end
    tick();                                   // cycle 3: IDLE, m_ack still high
    i_req = 1'b0;
    nbad = 0;
    repeat (3) begin
      @(negedge clk);
      if ({busy, m_req, i_ack, d_ack} !== 4'b0000) nbad++;
    end
    tests_run++;
    if (nbad != 0) begin
      tests_failed++;
      $display("FAIL spur_after_resp got %0d active cycles want 0", nbad);
    end
    tests_run++;
    if (i_rdata !== 32'h13579BDF || d_rdata !== d_before) begin
      tests_failed++;
      $display("FAIL spur_hold got i=%h d=%h want %h %h", i_rdata, d_rdata, 32'h13579BDF, d_before);
    end
    tick();
    man_ack = 1'b0; mem_auto = 1'b1;
    $display("[TB] spurious m_ack ignored in IDLE and RESP");
  endtask

  task automatic test_reset_mid_busy();
    bit seen = 1'b0;
    int nbad = 0;
    mem_auto = 1'b1; mem_lat = 0;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_op = MEM_W; d_addr = 32'h3000; d_wdata = 32'h11112222;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (m_req) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL rst_mid_wait got no m_req want m_req within 10 cycles");
    end
    #1 resetn = 1'b0;
    #1;
    tests_run++;
    if ({m_req, busy, i_ack, d_ack, err} !== 5'b00000 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_async got ctrl=%b addr=%h wdata=%h want 00000 0 0",
               {m_req, busy, i_ack, d_ack, err}, m_addr, m_wdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if ({m_req, busy, i_ack, d_ack} !== 4'b0000) nbad++;
    end
    tests_run++;
    if (nbad != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_stay_idle got %0d active cycles want 0", nbad);
    end
    $display("[TB] reset during BUSY dropped the access");
  endtask

  task automatic test_timeout();
    int mreq_cycles = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    exp_t e;
    bit   done = 1'b0;
    int   nerr = 0;
    mem_auto = 1'b1; mem_lat = 0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_op = MEM_W; d_addr = 32'h5000;
    push_d(32'h5000, 32'hDEADBEEF);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (m_req) mreq_cycles++;
      if (d_ack) begin
        tests_run++;
        e = sb_d.pop_front();
        if (d_rdata !== e.rdata || err !== 1'b1) begin
          tests_failed++;
          $display("FAIL to_resp got rdata=%h err=%b want %h 1", d_rdata, err, e.rdata);
        end
        tick();
        d_req = 1'b0;
        done = 1'b1;
      end
    end
    tests_run++;
    if (!done || mreq_cycles < TIMEOUT_CYCLES || mreq_cycles > TIMEOUT_CYCLES + 1) begin
      tests_failed++;
      $display("FAIL to_abort got done=%b busy_cycles=%0d want 1 %0d..%0d", done, mreq_cycles,
               TIMEOUT_CYCLES, TIMEOUT_CYCLES + 1);
    end
    mem_lat = 1;
    tick();
    i_req = 1'b1; i_addr = 32'h600;
    repeat (2) @(negedge clk);
    tick();
    i_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (err !== 1'b1) nerr++;
    end
    tests_run++;
    if (nerr != 0) begin
      tests_failed++;
      $display("FAIL to_err_sticky got %0d cycles with err=0 want 0", nerr);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_err_reset got %b want 0", err);
    end
`else
    int err_cycles = 0;
    mem_auto = 1'b1; mem_lat = 0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_op = MEM_W; d_addr = 32'h5000;
    repeat (100) begin
      @(negedge clk);
      if (m_req === 1'b1) mreq_cycles++;
      if (err !== 1'b0 || d_ack !== 1'b0) err_cycles++;
    end
    tests_run++;
    if (mreq_cycles < 99) begin
      tests_failed++;
      $display("FAIL no_to_hold got m_req for %0d of 100 cycles want >=99", mreq_cycles);
    end
    tests_run++;
    if (err_cycles != 0) begin
      tests_failed++;
      $display("FAIL no_to_err got %0d cycles with err/d_ack want 0", err_cycles);
    end
    resetn = 1'b0;
    d_req = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, m_req, err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL no_to_recover got busy=%b m_req=%b err=%b want 0 0 0", busy, m_req, err);
    end
`endif
    $display("[TB] timeout scenario busy_cycles=%0d", mreq_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_spurious_ack();
    test_reset_mid_busy();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory between the instruction-fetch port and the data-memory port of the five-stage core. Each requester uses a req/ack handshake. The downstream memory uses a req/ack handshake with variable latency. The block grants one requester at a time, registers the transaction onto the memory bus, and returns read data with a one-cycle ack pulse; the core uses the pending req/no-ack window as its stall condition.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending (≥1)
- TIMEOUT_CYCLES, 255, busy cycles without m_ack before abort (only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with fields stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_op  in  mem_op_t  access size/sign
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse for data
- m_req  out  1  memory request, held until m_ack sampled
- m_we, m_op, m_addr, m_wdata  out  1/mem_op_t/ADDR_W/DATA_W  registered transaction fields
- m_rdata  in  DATA_W  memory read data, valid with m_ack
- m_ack  in  1  memory completion, sampled only in BUSY
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag (0 when timeout is not compiled in)

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE -> BUSY when i_req|d_req.
  - Grant: data if d_req and (!i_req or streak < STARVE_LIMIT); otherwise fetch.
  - Latch winner's fields into m_*.
  - Fetch grant drives m_we=0, m_op=word-load value of mem_op_t, m_wdata=0.
  - Record owner.
- BUSY: m_req=1. On m_ack: capture m_rdata into owner's rdata register -> RESP.
- RESP: owner's ack=1 for exactly one cycle; m_req=0 -> IDLE.
- Non-owner ack is always 0. Non-owner rdata holds its last value.
- Starvation counter `streak` (3+ bits, saturating at STARVE_LIMIT):
  - Increments on a data grant while i_req=1.
  - Clears on a fetch grant, or in IDLE when i_req=0.
- Requester drops or changes req the cycle after sampling ack. The arbiter sees the new req in IDLE, so a completed request is never re-granted.
- m_ack outside BUSY is ignored. Stores return d_rdata = m_rdata as presented (don't-care for the core).
- Reset (any time, including mid-transaction) → IDLE.
  - m_req=0, all acks=0, m_*/rdata=0, streak=0, err=0.
  - The in-flight transaction is dropped and not replayed.

## Timing
- Request seen in IDLE at cycle 0 -> m_req=1 from cycle 1.
- m_ack at cycle k≥1 -> x_ack/x_rdata at cycle k+1 -> IDLE at k+2.
- Minimum request-to-ack: 2 cycles (m_ack=1 at cycle 1). Back-to-back transactions every 3 cycles minimum.
- m_req deasserts the cycle after m_ack is sampled.
- m_* fields are constant for the entire BUSY period.
- All outputs registered; no combinational path from any input to any output.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - 8+-bit counter clears on BUSY entry and counts BUSY cycles.
  - When the count reaches TIMEOUT_CYCLES with no m_ack: go to RESP, pulse owner ack with rdata=32'hDEADBEEF, set err=1.
  - err stays 1 until reset.
  - m_ack in the same cycle as expiry wins (normal completion, no err).
- Undefined: BUSY waits indefinitely; err tied 0; no counter logic.

## Test plan
- Single fetch: i_req=1, i_addr=0x100, memory acks 1 cycle after m_req with 0x00500093 -> m_addr=0x100, m_we=0, i_ack pulse with i_rdata=0x00500093 at cycle 2; busy low at cycle 3.
- Store: d_req, d_we=1, d_addr=0x2000, d_wdata=0xCAFEF00D, m_ack latency 4 -> m_we=1 and fields stable for 4 BUSY cycles, d_ack one cycle, i_ack never asserted.
- Contention/starvation, STARVE_LIMIT=4: i_req and d_req held high continuously -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Reset mid-BUSY: assert resetn=0 while m_req=1 -> m_req, acks, busy, err all 0 immediately (asynchronous); after release with no reqs, stays IDLE.
- Spurious ack: m_ack=1 in IDLE and RESP -> no ack pulse, no state change.
- Timeout, macro defined, TIMEOUT_CYCLES=8, m_ack held 0 -> m_req drops, d_ack with d_rdata=0xDEADBEEF, err=1 sticky. Macro undefined: m_req held for 100 cycles, err=0.
